booth_mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one signed Booth multiplier among NREQ requesters. It latches the winning requester's operands and issues a single-cycle start to the multiplier. It then holds the operands stable until the multiplier's valid, and returns the product to the owner with a one-cycle done pulse. A watchdog recovers from a multiplier that never asserts valid.

---
 rtl/booth_mult_arbiter_if.sv | 38 +++
 rtl/booth_mult_arbiter.sv | 140 ++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_arbiter_if.sv
//------------------------------------------------------------------------------
// booth_mult_arbiter_if
// Requester and multiplier bus of the shared Booth multiplier arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface booth_mult_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] x_in;
   logic [NREQ*W-1:0] y_in;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   done;
   logic [2*W-1:0]    result;
   logic              err;
   logic              busy;
   logic              mul_start;
   logic [W-1:0]      mul_x;
   logic [W-1:0]      mul_y;
   logic              mul_valid;
   logic [2*W-1:0]    mul_z;

   modport slave (
      input  req, x_in, y_in, mul_valid, mul_z,
      output grant, done, result, err, busy, mul_start, mul_x, mul_y
   );

   modport master (
      output req, x_in, y_in, mul_valid, mul_z,
      input  grant, done, result, err, busy, mul_start, mul_x, mul_y
   );
endinterface

`default_nettype wire

// File: rtl/booth_mult_arbiter.sv
//------------------------------------------------------------------------------
// booth_mult_arbiter
// Round-robin sequencer sharing one signed Booth multiplier, with watchdog.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module booth_mult_arbiter #(
   parameter int NREQ    = 4,
   parameter int W       = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   booth_mult_arbiter_if.slave  bus
);
   localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WDW = $clog2(TIMEOUT);
   localparam logic [NREQ-1:0] c_one      = NREQ'(1);
   localparam logic [WDW-1:0]  c_wdog_max = WDW'(TIMEOUT - 1);
   localparam logic [PW-1:0]   c_last     = PW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t          r_state;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_owner;
   logic [WDW-1:0]  r_wdog;
   logic [NREQ-1:0] r_grant;
   logic [NREQ-1:0] r_done;
   logic [2*W-1:0]  r_result;
   logic            r_err;
   logic            r_busy;
   logic            r_mul_start;
   logic [W-1:0]    r_mul_x;
   logic [W-1:0]    r_mul_y;

   logic [W-1:0]    w_x [NREQ];
   logic [W-1:0]    w_y [NREQ];
   logic            w_found;
   logic [PW-1:0]   w_winner;
   int              w_idx;

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign w_x[i] = bus.x_in[i*W +: W];
      assign w_y[i] = bus.y_in[i*W +: W];
   end

   // Scan from the largest offset down so the nearest request at/after ptr wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_idx = (int'(r_ptr) + k) % NREQ;
         if (bus.req[w_idx]) begin
            w_found  = 1'b1;
            w_winner = PW'(w_idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_owner     <= '0;
         r_wdog      <= '0;
         r_grant     <= '0;
         r_done      <= '0;
         r_result    <= '0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_mul_start <= 1'b0;
         r_mul_x     <= '0;
         r_mul_y     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_grant     <= c_one << w_winner;
                  r_owner     <= w_winner;
                  r_mul_x     <= w_x[w_winner];
                  r_mul_y     <= w_y[w_winner];
                  r_mul_start <= 1'b1;
                  r_busy      <= 1'b1;
                  r_ptr       <= (w_winner == c_last) ? '0 : w_winner + 1'b1;
                  r_state     <= LAUNCH;
               end
            end
            LAUNCH: begin
               r_grant     <= '0;
               r_mul_start <= 1'b0;
               r_wdog      <= '0;
               r_state     <= WAIT;
            end
            WAIT: begin
               // A valid on the timeout edge still counts as a good completion.
               if (bus.mul_valid) begin
                  r_result <= bus.mul_z;
                  r_done   <= c_one << r_owner;
                  r_state  <= RESP;
               end else if (r_wdog == c_wdog_max) begin
                  r_result <= '0;
                  r_done   <= c_one << r_owner;
                  r_err    <= 1'b1;
                  r_state  <= RESP;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            RESP: begin
               r_done  <= '0;
               r_err   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.grant     = r_grant;
   assign bus.done      = r_done;
   assign bus.result    = r_result;
   assign bus.err       = r_err;
   assign bus.busy      = r_busy;
   assign bus.mul_start = r_mul_start;
   assign bus.mul_x     = r_mul_x;
   assign bus.mul_y     = r_mul_y;

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_arbiter.sv
//------------------------------------------------------------------------------
// tb_booth_mult_arbiter
// Self-checking bench for booth_mult_arbiter with a 4-cycle multiplier stub.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_booth_mult_arbiter;
   localparam int NREQ    = 4;
   localparam int W       = 4;
   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   booth_mult_arbiter_if #(.NREQ(NREQ), .W(W)) bus();

   booth_mult_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Multiplier stub: samples start, pulses valid four edges later using the
   // operands present at that moment (so it also sees whether they were held).
   logic       stub_en    = 1'b1;
   logic       inj_valid  = 1'b0;
   logic       stub_valid = 1'b0;
   logic [2:0] stub_cnt   = 3'd0;
   logic [7:0] stub_z     = 8'd0;

   always @(posedge clk) begin
      stub_valid <= 1'b0;
      if (stub_cnt != 3'd0) begin
         stub_cnt <= stub_cnt - 3'd1;
         if (stub_cnt == 3'd1 && stub_en) begin
            stub_valid <= 1'b1;
            stub_z     <= {{4{bus.mul_x[3]}}, bus.mul_x} * {{4{bus.mul_y[3]}}, bus.mul_y};
         end
      end
      if (bus.mul_start) stub_cnt <= 3'd4;
   end

   assign bus.mul_valid = stub_valid | inj_valid;
   assign bus.mul_z     = stub_z;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] x;
      logic [15:0] y;
      logic [3:0]  g;
      logic [7:0]  r;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(output logic [3:0] g, output int t);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.grant == 4'd0 && n < 40);
      g = bus.grant;
      t = cyc;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.done == 4'd0 && n < 60);
   endtask

   task automatic check_zero_outs(input string name);
      check(name, 32'({bus.grant, bus.done, bus.result, bus.err, bus.busy,
                       bus.mul_start, bus.mul_x, bus.mul_y}), 32'd0);
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      int n;
      bus.req  = v.req;
      bus.x_in = v.x;
      bus.y_in = v.y;
      tick();
      check({tag, "_grant"}, 32'({bus.grant, bus.mul_start, bus.busy}), 32'({v.g, 2'b11}));
      bus.req = 4'd0;
      tick();
      check({tag, "_start_drop"}, 32'({bus.grant, bus.mul_start}), 32'd0);
      wait_done(n);
      check({tag, "_latency"}, 32'(n + 1), 32'd6);
      check({tag, "_done"}, 32'({bus.done, bus.err, bus.result}), 32'({v.g, 1'b0, v.r}));
      tick();
      check({tag, "_end"}, 32'({bus.busy, bus.done, bus.err, bus.result}), 32'({6'd0, v.r}));
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] g;
      int         t, tp, n;
      logic       saw;
      vec_t       v;

      // ptr sequence after reset: 0 -> 1 -> 3 -> 0 -> 2 -> 1 -> 2
      tbl[0] = '{4'b0001, 16'h0003, 16'h000E, 4'b0001, 8'hFA};
      tbl[1] = '{4'b0100, 16'h0800, 16'h0800, 4'b0100, 8'h40};
      tbl[2] = '{4'b1001, 16'h7000, 16'h8000, 4'b1000, 8'hC8};
      tbl[3] = '{4'b0110, 16'h00F0, 16'h0050, 4'b0010, 8'hFB};
      tbl[4] = '{4'b0011, 16'h0009, 16'h0009, 4'b0001, 8'h31};
      tbl[5] = '{4'b1111, 16'h0000, 16'h0050, 4'b0010, 8'h00};

      bus.req  = 4'd0;
      bus.x_in = 16'd0;
      bus.y_in = 16'd0;
      tick();
      tick();
      check_zero_outs("reset_state");
      rst = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

      // Simultaneous requests straight after reset.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      bus.req  = 4'hF;
      bus.x_in = 16'h4321;
      bus.y_in = 16'h2222;
      tp = 0;
      for (int k = 0; k < 5; k++) begin
         wait_grant(g, t);
         check($sformatf("rr_grant%0d", k), 32'(g), 32'(4'b0001 << (k % 4)));
         if (k > 0) check($sformatf("rr_spacing%0d", k), 32'(t - tp), 32'd8);
         tp = t;
         wait_done(n);
         check($sformatf("rr_done%0d", k), 32'({bus.done, bus.result}),
               32'({4'(4'b0001 << (k % 4)), 8'(2 * (k % 4 + 1))}));
      end
      bus.req = 4'd0;
      tick();
      tick();
      check("rr_idle", 32'({bus.busy, bus.grant}), 32'd0);

      // Fairness: req0 held, req2 joins mid-service (ptr is 1 here).
      bus.req  = 4'b0001;
      bus.x_in = 16'h0005;
      bus.y_in = 16'h0001;
      wait_grant(g, tp);
      check("fair_grant0", 32'(g), 32'b0001);
      tick();
      tick();
      tick();
      bus.req  = 4'b0101;
      bus.x_in = 16'h0205;
      bus.y_in = 16'h0301;
      wait_done(n);
      check("fair_res0", 32'({bus.done, bus.result}), 32'({4'b0001, 8'h05}));
      wait_grant(g, t);
      check("fair_grant2", 32'(g), 32'b0100);
      check("fair_spacing", 32'(t - tp), 32'd8);
      wait_done(n);
      check("fair_res2", 32'({bus.done, bus.result}), 32'({4'b0100, 8'h06}));
      wait_grant(g, t);
      check("fair_grant0b", 32'(g), 32'b0001);
      bus.req = 4'd0;
      wait_done(n);
      tick();
      check("fair_idle", 32'(bus.busy), 32'd0);

      // Watchdog timeout with a silent multiplier.
      stub_en  = 1'b0;
      bus.req  = 4'b0010;
      bus.x_in = 16'h0050;
      bus.y_in = 16'h0050;
      wait_grant(g, t);
      check("to_grant", 32'(g), 32'b0010);
      bus.req = 4'd0;
      wait_done(n);
      check("to_latency", 32'(n), 32'd16);
      check("to_done", 32'({bus.done, bus.err, bus.result}), 32'({4'b0010, 1'b1, 8'h00}));
      check("to_operands_held", 32'({bus.mul_x, bus.mul_y}), 32'h55);
      tick();
      check("to_idle", 32'({bus.busy, bus.done, bus.err}), 32'd0);
      check("to_operands_kept", 32'({bus.mul_x, bus.mul_y}), 32'h55);
      stub_en = 1'b1;

      // Reset two cycles into an operation (ptr is 3 afterwards if not reset).
      bus.req  = 4'b0100;
      bus.x_in = 16'h0300;
      bus.y_in = 16'h0300;
      wait_grant(g, t);
      check("rst_grant", 32'(g), 32'b0100);
      bus.req = 4'd0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_zero_outs("rst_async_outs");
      tick();
      tick();
      rst = 1'b1;
      saw = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (bus.done != 4'd0 || bus.busy) saw = 1'b1;
      end
      check("rst_no_done", 32'(saw), 32'd0);
      v = '{4'b1010, 16'h7020, 16'h1030, 4'b0010, 8'h06};
      apply_vec(v, "rst_after");

      // Request withdrawn just before the arbitration edge.
      bus.req = 4'b0010;
      @(negedge clk);
      bus.req = 4'd0;
      tick();
      check("wd_no_grant", 32'({bus.grant, bus.busy, bus.mul_start}), 32'd0);
      tick();
      check("wd_still_idle", 32'({bus.grant, bus.busy}), 32'd0);

      // Stray multiplier valid while idle.
      inj_valid = 1'b1;
      tick();
      inj_valid = 1'b0;
      check("stray_valid", 32'({bus.done, bus.err, bus.busy, bus.result}), 32'h006);
      tick();
      check("stray_after", 32'({bus.done, bus.busy}), 32'd0);
      v = '{4'b0001, 16'h000F, 16'h000F, 4'b0001, 8'h01};
      apply_vec(v, "post_stray");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

`default_nettype wire
